// File: rtl/layer0_accumulator.sv
// rtl/layer0_accumulator.sv - layer-0 MAC accumulator: bias load, per-pixel weight-row MAC, ReLU output
// Zero pixels skip the weight fetch entirely; each nonzero pixel fetches one row and runs NEURONS/LANES MAC beats.
module layer0_accumulator #(
    parameter int NEURONS = 56,
    parameter int PIXELS  = 784,
    parameter int LANES   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [9:0]             pixel_addr,
    input  logic [7:0]             pixel_data,
    output logic                   b0_fetch,
    output logic                   w0_fetch,
    output logic [9:0]             pixel_no,
    input  logic                   b0_complete,
    input  logic                   w0_complete,
    input  logic [0:NEURONS*16-1]  l1_reg,
    input  logic [0:NEURONS*16-1]  weight_reg,
    output logic [0:NEURONS*16-1]  hidden_reg
);

    localparam int STEPS = NEURONS / LANES;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_B_REQ  = 4'd1;
    localparam logic [3:0] S_B_LOAD = 4'd2;
    localparam logic [3:0] S_P_RD   = 4'd3;
    localparam logic [3:0] S_P_CHK  = 4'd4;
    localparam logic [3:0] S_W_GAP  = 4'd5;
    localparam logic [3:0] S_W_REQ  = 4'd6;
    localparam logic [3:0] S_MAC    = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_RELU   = 4'd9;
    localparam logic [3:0] S_DONE   = 4'd10;

    logic [3:0]         state;
    logic [9:0]         counter;
    logic [7:0]         px;
    logic [KW-1:0]      mac_k;
    logic signed [15:0] acc [NEURONS];

    // Q8.8 weight times Q0.8 pixel, rescaled to Q8.8 and added with saturation.
    function automatic logic signed [15:0] sat_mac(input logic signed [15:0] a,
                                                   input logic signed [15:0] w,
                                                   input logic [7:0]         p);
        logic signed [24:0] prod;
        logic signed [24:0] sum;
        prod = w * $signed({1'b0, p});
        sum  = $signed({{9{a[15]}}, a}) + (prod >>> 8);
        if (sum > 25'sd32767)
            return 16'sh7FFF;
        else if (sum < -25'sd32768)
            return -16'sd32768;
        else
            return sum[15:0];
    endfunction

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign b0_fetch   = (state == S_B_REQ);
    assign w0_fetch   = (state == S_W_REQ);
    assign pixel_addr = counter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            counter    <= '0;
            px         <= '0;
            mac_k      <= '0;
            pixel_no   <= '0;
            hidden_reg <= '0;
            for (int n = 0; n < NEURONS; n++)
                acc[n] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_B_REQ;
                        counter <= '0;
                    end
                end
                S_B_REQ: begin
                    if (b0_complete)
                        state <= S_B_LOAD;
                end
                S_B_LOAD: begin
                    for (int n = 0; n < NEURONS; n++)
                        acc[n] <= l1_reg[n*16 +: 16];
                    state <= S_P_RD;
                end
                S_P_RD: begin
                    state <= S_P_CHK;
                end
                S_P_CHK: begin
                    px    <= pixel_data;
                    state <= (pixel_data == 8'd0) ? S_NEXT : S_W_GAP;
                end
                S_W_GAP: begin
                    // One idle cycle guarantees each row request starts on a fresh rising edge.
                    pixel_no <= counter;
                    state    <= S_W_REQ;
                end
                S_W_REQ: begin
                    if (w0_complete) begin
                        mac_k <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int n = 0; n < NEURONS; n++) begin
                        if ((n / LANES) == int'(mac_k))
                            acc[n] <= sat_mac(acc[n], weight_reg[n*16 +: 16], px);
                    end
                    if (mac_k == KW'(STEPS - 1))
                        state <= S_NEXT;
                    else
                        mac_k <= mac_k + 1'b1;
                end
                S_NEXT: begin
                    if (counter == 10'(PIXELS - 1)) begin
                        state <= S_RELU;
                    end else begin
                        counter <= counter + 10'd1;
                        state   <= S_P_RD;
                    end
                end
                S_RELU: begin
                    for (int n = 0; n < NEURONS; n++)
                        hidden_reg[n*16 +: 16] <= acc[n][15] ? 16'h0000 : acc[n];
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer0_accumulator.sv
// tb/tb_layer0_accumulator.sv - self-checking bench for layer0_accumulator
module tb_layer0_accumulator;

    localparam int NEURONS = 56;
    localparam int PIXELS  = 784;
    localparam int LANES   = 8;
    localparam int W       = NEURONS * 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy, done, b0_fetch, w0_fetch;
    logic [9:0]   pixel_addr, pixel_no;
    logic [7:0]   pixel_data;
    logic         b0_complete, w0_complete;
    logic [0:W-1] l1_reg, weight_reg, hidden_reg;

    layer0_accumulator #(.NEURONS(NEURONS), .PIXELS(PIXELS), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pixel_addr(pixel_addr), .pixel_data(pixel_data),
        .b0_fetch(b0_fetch), .w0_fetch(w0_fetch), .pixel_no(pixel_no),
        .b0_complete(b0_complete), .w0_complete(w0_complete),
        .l1_reg(l1_reg), .weight_reg(weight_reg), .hidden_reg(hidden_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         img;
        int         wt;
        int         bias;
        int         bdelay;
        int         wdelay;
        int         chk_word;   // >=0 one word, -1 every word, -2 model only
        logic [15:0] chk_val;
        int         start_mid;
        bit         stray;
    } vec_t;

    vec_t         vecs[7];
    bit [7:0]     image[PIXELS];
    logic [0:W-1] bias_vec;
    logic [0:W-1] sb[$];
    int cur_wt, cur_bias, bdelay, wdelay;
    int n_checks = 0;
    int n_fail = 0;
    int fetch_count, exp_fetch, wpix;
    bit stray_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wt_word(input int mode, input int p, input int n);
        int h;
        case (mode)
            0: return 16'h0100;
            1: return 16'h7FFF;
            2: return 16'h8000;
            default: begin
                h = (p * 131 + n * 29 + 7) % 1024;
                return 16'(h * 8 - 4096);
            end
        endcase
    endfunction

    function automatic logic [15:0] bias_word(input int mode, input int n);
        case (mode)
            0: return 16'h0000;
            1: return 16'(n * 256 - 7168);
            default: return 16'(((n * 97) % 512) * 16 - 4096);
        endcase
    endfunction

    function automatic logic [7:0] img_val(input int mode, input int p);
        case (mode)
            0: return 8'd0;
            1: return (p == 400) ? 8'd255 : 8'd0;
            2: return 8'd255;
            3: begin
                if (p == 0 || p == 783) return 8'd200;
                return (p % 61 == 7) ? 8'((p * 53) % 256) : 8'd0;
            end
            default: begin
                if (p == 10) return 8'd128;
                if (p == 11) return 8'd255;
                return (p == 783) ? 8'd1 : 8'd0;
            end
        endcase
    endfunction

    function automatic logic [0:W-1] row(input int p);
        logic [0:W-1] r;
        for (int n = 0; n < NEURONS; n++)
            r[n*16 +: 16] = wt_word(cur_wt, p, n);
        return r;
    endfunction

    function automatic logic [0:W-1] model();
        logic [0:W-1] r;
        int a, w, pr;
        for (int n = 0; n < NEURONS; n++) begin
            a = int'($signed(bias_word(cur_bias, n)));
            for (int p = 0; p < PIXELS; p++) begin
                if (image[p] != 8'd0) begin
                    w  = int'($signed(wt_word(cur_wt, p, n)));
                    pr = w * int'(image[p]);
                    a  = a + (pr >>> 8);
                    if (a > 32767) a = 32767;
                    else if (a < -32768) a = -32768;
                end
            end
            r[n*16 +: 16] = (a < 0) ? 16'h0000 : 16'(a);
        end
        return r;
    endfunction

    // Image buffer: data for the address seen one cycle earlier.
    initial begin : pixmem
        logic [9:0] a_d;
        a_d = '0;
        pixel_data = '0;
        forever begin
            @(negedge clk);
            pixel_data = (a_d < 10'(PIXELS)) ? image[a_d] : 8'd0;
            a_d = pixel_addr;
        end
    end

    // Fetch responder and handshake monitor.
    initial begin : responder
        int bcnt, wcnt;
        bit wprev;
        b0_complete = 1'b0; w0_complete = 1'b0;
        l1_reg = '0; weight_reg = '0;
        bcnt = 0; wcnt = 0; wprev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                b0_complete = 1'b0; w0_complete = 1'b0;
                bcnt = 0; wcnt = 0; wprev = 1'b0;
            end else if (stray_req) begin
                b0_complete = 1'b1; w0_complete = 1'b1;
                stray_req = 1'b0;
            end else begin
                if (b0_fetch || w0_fetch)
                    chk("fetch_exclusive", 32'(b0_fetch && w0_fetch), 0);
                if (b0_complete) begin
                    b0_complete = 1'b0;
                    chk("b0_drop", 32'(b0_fetch), 0);
                end else if (b0_fetch) begin
                    if (bcnt >= bdelay) begin
                        l1_reg = bias_vec; b0_complete = 1'b1; bcnt = 0;
                    end else bcnt++;
                end
                if (w0_complete) begin
                    w0_complete = 1'b0;
                    chk("w0_drop", 32'(w0_fetch), 0);
                end else if (w0_fetch) begin
                    if (!wprev) begin
                        wpix = int'(pixel_no);
                        fetch_count++;
                        chk("w0_pixel_nonzero", 32'(pixel_no < 10'(PIXELS) && image[pixel_no] != 8'd0), 1);
                    end else begin
                        chk("pixel_no_stable", 32'(pixel_no), 32'(wpix));
                    end
                    if (wcnt >= wdelay) begin
                        weight_reg = row(wpix); w0_complete = 1'b1; wcnt = 0;
                    end else wcnt++;
                end
                wprev = w0_fetch;
            end
        end
    end

    // Scoreboard: pop the expected hidden vector on every done pulse.
    initial begin : scoreboard
        logic [0:W-1] e;
        int bad;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (hidden_reg !== e) begin
                        n_fail++;
                        bad = 0;
                        for (int n = NEURONS - 1; n >= 0; n--)
                            if (hidden_reg[n*16 +: 16] !== e[n*16 +: 16]) bad = n;
                        $display("FAIL hidden_reg word %0d: got %h expected %h",
                                 bad, hidden_reg[bad*16 +: 16], e[bad*16 +: 16]);
                    end
                end
            end
        end
    end

    task automatic setup(input vec_t v);
        cur_wt = v.wt; cur_bias = v.bias; bdelay = v.bdelay; wdelay = v.wdelay;
        exp_fetch = 0;
        for (int p = 0; p < PIXELS; p++) begin
            image[p] = img_val(v.img, p);
            if (image[p] != 8'd0) exp_fetch++;
        end
        for (int n = 0; n < NEURONS; n++)
            bias_vec[n*16 +: 16] = bias_word(v.bias, n);
        fetch_count = 0;
        sb.push_back(model());
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit ok;
        setup(v);
        if (v.stray) begin
            @(negedge clk);
            stray_req = 1'b1;
            repeat (4) @(negedge clk);
            chk("stray_idle_busy", 32'(busy), 0);
            chk("stray_idle_fetch", 32'(b0_fetch | w0_fetch), 0);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 2;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (v.start_mid != 0 && cyc == v.start_mid);
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 1);
        if (v.img == 0)
            chk("latency", 32'(cyc), 32'(PIXELS * 3 + (bdelay + 1) + 4));
        chk("fetch_count", 32'(fetch_count), 32'(exp_fetch));
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        if (v.chk_word >= 0) begin
            chk("hidden_word", 32'(hidden_reg[v.chk_word*16 +: 16]), 32'(v.chk_val));
        end else if (v.chk_word == -1) begin
            ok = 1'b1;
            for (int n = 0; n < NEURONS; n++)
                if (hidden_reg[n*16 +: 16] !== v.chk_val) ok = 1'b0;
            chk("hidden_all_words", 32'(ok), 1);
        end
        repeat (20) @(negedge clk);
        chk("no_restart", 32'(busy | b0_fetch | w0_fetch), 0);
    endtask

    initial begin : main
        vec_t r;
        int cnt;
        reset = 1'b1; start = 1'b0; stray_req = 1'b0;
        cur_wt = 0; cur_bias = 0; bdelay = 0; wdelay = 0; wpix = 0;
        fetch_count = 0; exp_fetch = 0; bias_vec = '0;
        for (int p = 0; p < PIXELS; p++) image[p] = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fetch", 32'({b0_fetch, w0_fetch}), 0);
        chk("rst_pixel_no", 32'(pixel_no), 0);
        chk("rst_pixel_addr", 32'(pixel_addr), 0);
        chk("rst_hidden", 32'(hidden_reg == '0), 1);
        reset = 1'b0;

        vecs[0] = '{0, 0, 1, 2, 0, 55, 16'h1B00, 0, 1'b0};
        vecs[1] = '{1, 0, 0, 0, 1, -1, 16'h00FF, 0, 1'b0};
        vecs[2] = '{2, 1, 0, 1, 0, -1, 16'h7FFF, 0, 1'b0};
        vecs[3] = '{2, 2, 2, 0, 0, -1, 16'h0000, 0, 1'b0};
        vecs[4] = '{4, 3, 2, 3, 10, -2, 16'h0000, 0, 1'b0};
        vecs[5] = '{3, 3, 1, 0, 2, -2, 16'h0000, 0, 1'b0};
        vecs[6] = '{0, 0, 2, 1, 0, 27, 16'h0000, 100, 1'b1};
        for (int i = 0; i < 7; i++)
            run_vec(vecs[i]);

        // Abandon a run during the MAC of pixel 300, then rerun cleanly.
        r = '{2, 0, 0, 0, 0, -2, 16'h0000, 0, 1'b0};
        setup(r);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (!(w0_fetch && pixel_no == 10'd300) && cnt < 20000) begin
            @(negedge clk); cnt++;
        end
        while (w0_fetch && cnt < 20000) begin
            @(negedge clk); cnt++;
        end
        chk("reached_pixel_300", 32'(cnt < 20000), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_fetch", 32'({b0_fetch, w0_fetch}), 0);
        chk("midrst_pixel_no", 32'(pixel_no), 0);
        chk("midrst_pixel_addr", 32'(pixel_addr), 0);
        chk("midrst_hidden", 32'(hidden_reg == '0), 1);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 0);
        end
        reset = 1'b0;
        run_vec(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
